// File: rtl/nihilist_pkg.sv
// Shared constants and helpers for the Nihilist stream cipher on the MATEI Polybius square.
package nihilist_pkg;

  localparam int unsigned SQ_DIM          = 5;
  localparam int unsigned SQ_CELLS        = SQ_DIM * SQ_DIM;
  localparam int unsigned DEFAULT_KEY_LEN = 9;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [7:0] ERR_CHAR = 8'h00;
  localparam logic [7:0] PAD_CHAR = "A";

  // Row-major square; the first character of the string occupies the top byte.
  localparam logic [SQ_CELLS-1:0][7:0]        SQUARE      = "MATEIBCDFGHKLNOPQRSUVWXYZ";
  localparam logic [DEFAULT_KEY_LEN-1:0][7:0] DEFAULT_KEY = "PARASCHIV";

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } beat_t;

  function automatic logic [7:0] square_char(input int unsigned idx);
    return SQUARE[5'(SQ_CELLS - 1 - idx)];
  endfunction

  // Cell index to 10*row + col, both counted from 1.
  function automatic logic [7:0] square_code(input int unsigned idx);
    return 8'((idx / SQ_DIM + 1) * 10 + (idx % SQ_DIM) + 1);
  endfunction

  function automatic logic [7:0] default_key_char(input int unsigned idx);
    logic [7:0] ch;
    if (idx < DEFAULT_KEY_LEN) begin
      ch = DEFAULT_KEY[4'(DEFAULT_KEY_LEN - 1 - idx)];
    end else begin
      ch = PAD_CHAR;
    end
    return ch;
  endfunction

endpackage

// File: rtl/nihilist_lut.sv
// Bidirectional Polybius lookup: character to square code and square code to character.
module nihilist_lut
  import nihilist_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic [7:0] i_code,
  output logic       o_code_valid_c,
  output logic [7:0] o_code_c,
  output logic       o_char_valid_c,
  output logic [7:0] o_char_c
);

  // Every cell is compared against both inputs; at most one cell matches each.
  always_comb begin
    o_code_valid_c = 1'b0;
    o_code_c       = 8'h00;
    o_char_valid_c = 1'b0;
    o_char_c       = 8'h00;
    for (int unsigned idx = 0; idx < SQ_CELLS; idx++) begin
      if (i_char == square_char(idx)) begin
        o_code_valid_c = 1'b1;
        o_code_c       = square_code(idx);
      end
      if (i_code == square_code(idx)) begin
        o_char_valid_c = 1'b1;
        o_char_c       = square_char(idx);
      end
    end
  end

endmodule

// File: rtl/nihilist_stream_core.sv
// Streaming Nihilist encrypt/decrypt engine with a run-time loadable rotating key.
module nihilist_stream_core
  import nihilist_pkg::*;
#(
  parameter  int unsigned KEY_MAX_LEN = 16,
  localparam int unsigned KEY_IDX_W   = $clog2(KEY_MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_mode,
  input  logic                 i_key_wr,
  input  logic [KEY_IDX_W-1:0] i_key_idx,
  input  logic [7:0]           i_key_char,
  input  logic                 i_key_len_wr,
  input  logic [KEY_IDX_W:0]   i_key_len,
  input  logic                 i_in_valid,
  output logic                 o_in_ready_c,
  input  logic                 i_in_sop,
  input  logic [7:0]           i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [7:0]           o_out_data,
  output logic                 o_out_err
);

  localparam int unsigned          LEN_W   = KEY_IDX_W + 1;
  localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(KEY_MAX_LEN);

  logic [7:0]           r_key [KEY_MAX_LEN];
  logic [LEN_W-1:0]     r_key_len;
  logic [KEY_IDX_W-1:0] r_kpos;
  logic                 r_out_valid;
  beat_t                r_out;

  logic                 w_accept;
  logic [KEY_IDX_W-1:0] w_k;
  logic [LEN_W-1:0]     w_k_inc;
  logic [KEY_IDX_W-1:0] w_kpos_adv;
  logic [KEY_IDX_W-1:0] w_kpos_after_len;
  logic [LEN_W-1:0]     w_len_clamped;
  logic [7:0]           w_key_char;
  logic                 w_key_code_valid;
  logic [7:0]           w_key_code;
  logic                 w_key_rev_valid;
  logic [7:0]           w_key_rev_char;
  logic                 w_data_code_valid;
  logic [7:0]           w_data_code;
  logic                 w_plain_valid;
  logic [7:0]           w_plain;
  logic [8:0]           w_diff;
  logic                 w_key_idx_ok;
  beat_t                w_beat;
  logic                 w_unused_key;

  assign o_in_ready_c = !r_out_valid || i_out_ready;
  assign w_accept     = i_in_valid && o_in_ready_c;
  assign w_k          = i_in_sop ? '0 : r_kpos;
  assign w_key_char   = r_key[w_k];
  // Sign bit w_diff[8] marks a cipher number smaller than the key code.
  assign w_diff       = {1'b0, i_in_data} - {1'b0, w_key_code};
  assign w_key_idx_ok = LEN_W'(i_key_idx) < MAX_LEN;

  nihilist_lut u_key_lut (
    .i_char         (w_key_char),
    .i_code         (8'h00),
    .o_code_valid_c (w_key_code_valid),
    .o_code_c       (w_key_code),
    .o_char_valid_c (w_key_rev_valid),
    .o_char_c       (w_key_rev_char)
  );

  nihilist_lut u_data_lut (
    .i_char         (i_in_data),
    .i_code         (w_diff[7:0]),
    .o_code_valid_c (w_data_code_valid),
    .o_code_c       (w_data_code),
    .o_char_valid_c (w_plain_valid),
    .o_char_c       (w_plain)
  );

  assign w_unused_key = &{1'b0, w_key_rev_valid, w_key_rev_char};

  // A key character outside the square cannot produce a meaningful code, so it also flags an error.
  always_comb begin
    w_beat.err  = 1'b1;
    w_beat.data = ERR_CHAR;
    if (i_mode == MODE_ENC) begin
      if (w_key_code_valid && w_data_code_valid) begin
        w_beat.err  = 1'b0;
        w_beat.data = w_key_code + w_data_code;
      end
    end else if (w_key_code_valid && !w_diff[8] && w_plain_valid) begin
      w_beat.err  = 1'b0;
      w_beat.data = w_plain;
    end
  end

  always_comb begin
    w_k_inc          = LEN_W'(w_k) + LEN_W'(1);
    w_kpos_adv       = (w_k_inc >= r_key_len) ? '0 : w_k_inc[KEY_IDX_W-1:0];
    w_len_clamped    = i_key_len;
    if (i_key_len == '0) begin
      w_len_clamped = LEN_W'(1);
    end else if (i_key_len > MAX_LEN) begin
      w_len_clamped = MAX_LEN;
    end
    // A beat accepted alongside a length load counts as position 0 of the new rotation.
    w_kpos_after_len = (w_len_clamped == LEN_W'(1)) ? '0 : KEY_IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_kpos      <= '0;
      r_key_len   <= LEN_W'(DEFAULT_KEY_LEN);
      for (int unsigned i = 0; i < KEY_MAX_LEN; i++) begin
        r_key[KEY_IDX_W'(i)] <= default_key_char(i);
      end
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out       <= w_beat;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (i_key_len_wr) begin
        r_key_len <= w_len_clamped;
        r_kpos    <= w_accept ? w_kpos_after_len : '0;
      end else if (w_accept) begin
        r_kpos <= w_kpos_adv;
      end

      if (i_key_wr && w_key_idx_ok) begin
        r_key[i_key_idx] <= i_key_char;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out.data;
  assign o_out_err   = r_out.err;

endmodule

// File: tb/tb_nihilist_stream_core.sv
// Self-checking bench: directed cipher vectors plus randomized traffic against a behavioural model.
module tb_nihilist_stream_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_mode = 1'b0;
  logic       i_key_wr = 1'b0;
  logic [3:0] i_key_idx = '0;
  logic [7:0] i_key_char = '0;
  logic       i_key_len_wr = 1'b0;
  logic [4:0] i_key_len = '0;
  logic       i_in_valid = 1'b0;
  logic       o_in_ready_c;
  logic       i_in_sop = 1'b0;
  logic [7:0] i_in_data = '0;
  logic       o_out_valid;
  logic       i_out_ready = 1'b1;
  logic [7:0] o_out_data;
  logic       o_out_err;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  string SQ = "MATEIBCDFGHKLNOPQRSUVWXYZ";
  string DK = "PARASCHIV";

  nihilist_stream_core #(.KEY_MAX_LEN(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mode       (i_mode),
    .i_key_wr     (i_key_wr),
    .i_key_idx    (i_key_idx),
    .i_key_char   (i_key_char),
    .i_key_len_wr (i_key_len_wr),
    .i_key_len    (i_key_len),
    .i_in_valid   (i_in_valid),
    .o_in_ready_c (o_in_ready_c),
    .i_in_sop     (i_in_sop),
    .i_in_data    (i_in_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_out_err    (o_out_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic int code_of(input logic [7:0] ch);
    for (int i = 0; i < 25; i++) begin
      if (8'(SQ[i]) == ch) return 10 * (i / 5 + 1) + (i % 5) + 1;
    end
    return 0;
  endfunction

  function automatic void ref_beat(input logic m, input logic [7:0] din, input logic [7:0] kch,
                                   output logic [7:0] dout, output logic err);
    int ck, ci, d;
    ck   = code_of(kch);
    dout = 8'h00;
    err  = 1'b1;
    if (m == 1'b0) begin
      ci = code_of(din);
      if (ci != 0 && ck != 0) begin
        dout = 8'(ci + ck);
        err  = 1'b0;
      end
    end else begin
      d = int'(din) - ck;
      if (ck != 0 && d >= 11 && d <= 55 && d % 10 >= 1 && d % 10 <= 5) begin
        dout = 8'(SQ[(d / 10 - 1) * 5 + d % 10 - 1]);
        err  = 1'b0;
      end
    end
  endfunction

  // Behavioural model state
  logic [7:0] m_key [16];
  int         m_len;
  int         m_kpos;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_err = 1'b0;

  always @(posedge clk) begin : model
    bit         acc;
    int         k;
    int         nl;
    logic [7:0] d;
    logic       e;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_err   = 1'b0;
      m_kpos  = 0;
      m_len   = 9;
      for (int i = 0; i < 16; i++) m_key[i] = (i < 9) ? 8'(DK[i]) : 8'("A");
    end else begin
      acc = i_in_valid && (!m_valid || i_out_ready);
      k   = i_in_sop ? 0 : m_kpos;
      if (acc) begin
        ref_beat(i_mode, i_in_data, m_key[k], d, e);
        m_valid = 1'b1;
        m_data  = d;
        m_err   = e;
      end else if (i_out_ready) begin
        m_valid = 1'b0;
      end
      if (i_key_len_wr) begin
        nl     = (i_key_len == 0) ? 1 : ((int'(i_key_len) > 16) ? 16 : int'(i_key_len));
        m_len  = nl;
        m_kpos = (acc && nl > 1) ? 1 : 0;
      end else if (acc) begin
        m_kpos = (k + 1 == m_len) ? 0 : k + 1;
      end
      if (i_key_wr) m_key[i_key_idx] = i_key_char;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 32'(o_out_valid), 32'(m_valid));
      chk("in_ready", 32'(o_in_ready_c), 32'(!m_valid || i_out_ready));
      if (m_valid) begin
        chk("out_data", 32'(o_out_data), 32'(m_data));
        chk("out_err", 32'(o_out_err), 32'(m_err));
      end
    end
  end

  task automatic send(input logic m, input logic sop, input logic [7:0] d, input logic lw,
                      input logic [4:0] ln, input logic [7:0] exp_d, input logic exp_e,
                      input string name);
    @(posedge clk); #1;
    i_in_valid = 1'b1; i_mode = m; i_in_sop = sop; i_in_data = d;
    i_key_len_wr = lw; i_key_len = ln;
    @(posedge clk); #1;
    i_in_valid = 1'b0; i_in_sop = 1'b0; i_key_len_wr = 1'b0;
    @(negedge clk);
    chk(name, {23'd0, o_out_valid, o_out_err, o_out_data}, {23'd0, 1'b1, exp_e, exp_d});
  endtask

  task automatic load_key(input logic [3:0] idx, input logic [7:0] ch);
    @(posedge clk); #1;
    i_key_wr = 1'b1; i_key_idx = idx; i_key_char = ch;
    @(posedge clk); #1;
    i_key_wr = 1'b0;
  endtask

  task automatic set_len(input logic [4:0] n);
    @(posedge clk); #1;
    i_key_len_wr = 1'b1; i_key_len = n;
    @(posedge clk); #1;
    i_key_len_wr = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] m10 [10];
    int         r;
    m10 = '{8'd52, 8'd23, 8'd54, 8'd23, 8'd55, 8'd33, 8'd42, 8'd26, 8'd62, 8'd52};

    chk("model_code_D", 32'(code_of("D")), 32'd23);
    chk("model_code_Z", 32'(code_of("Z")), 32'd55);
    chk("model_code_J", 32'(code_of("J")), 32'd0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_state", {29'd0, o_out_valid, o_out_err, o_in_ready_c}, {29'd0, 1'b0, 1'b0, 1'b1});
    chk("reset_data", 32'(o_out_data), 32'd0);

    send(1'b0, 1'b1, "D", 1'b0, 5'd0, 8'd64, 1'b0, "enc_D");
    send(1'b1, 1'b1, 8'd64, 1'b0, 5'd0, "D", 1'b0, "dec_64");
    send(1'b1, 1'b0, 8'd24, 1'b0, 5'd0, "A", 1'b0, "dec_24");

    for (int i = 0; i < 10; i++)
      send(1'b0, (i == 0), "M", 1'b0, 5'd0, m10[i], 1'b0, $sformatf("enc_M%0d", i));

    send(1'b1, 1'b1, 8'd10, 1'b0, 5'd0, 8'h00, 1'b1, "dec_err");
    send(1'b1, 1'b0, 8'd24, 1'b0, 5'd0, "A", 1'b0, "dec_after_err");

    send(1'b0, 1'b1, "M", 1'b1, 5'd2, 8'd52, 1'b0, "sop_lenwr");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd23, 1'b0, "lenwr_next");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd52, 1'b0, "lenwr_wrap");
    set_len(5'd0);
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd52, 1'b0, "len0_a");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd52, 1'b0, "len0_b");
    set_len(5'd9);

    load_key(4'd0, "A");
    load_key(4'd1, "B");
    set_len(5'd2);
    send(1'b0, 1'b1, "M", 1'b0, 5'd0, 8'd23, 1'b0, "keyAB_0");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd32, 1'b0, "keyAB_1");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd23, 1'b0, "keyAB_2");

    // Backpressure hold, then reset while the beat is stalled.
    @(posedge clk); #1;
    i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_sop = 1'b1; i_mode = 1'b0; i_in_data = "M";
    @(posedge clk); #1;
    i_in_sop = 1'b0; i_in_data = "Z";
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 32'(o_in_ready_c), 32'd0);
      chk("hold_data", {23'd0, o_out_valid, o_out_err, o_out_data}, {23'd0, 1'b1, 1'b0, 8'd23});
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b1;
    @(negedge clk);
    chk("reset_drop", {23'd0, o_out_valid, o_out_err, o_out_data}, 32'd0);
    send(1'b0, 1'b1, "M", 1'b0, 5'd0, 8'd52, 1'b0, "revert_0");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd23, 1'b0, "revert_1");
    send(1'b0, 1'b0, "M", 1'b0, 5'd0, 8'd54, 1'b0, "revert_2");

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n       = ($urandom_range(0, 399) != 0);
      i_in_valid  = ($urandom_range(0, 3) != 0);
      i_out_ready = ($urandom_range(0, 4) != 0);
      i_mode      = 1'($urandom_range(0, 1));
      i_in_sop    = ($urandom_range(0, 9) == 0);
      r           = int'($urandom_range(0, 9));
      if (i_mode == 1'b0) begin
        if (r < 8)       i_in_data = 8'(SQ[$urandom_range(0, 24)]);
        else if (r == 8) i_in_data = "J";
        else             i_in_data = 8'($urandom_range(0, 255));
      end else begin
        if (r < 7) i_in_data = 8'(code_of(8'(SQ[$urandom_range(0, 24)])) + code_of(8'(SQ[$urandom_range(0, 24)])));
        else       i_in_data = 8'($urandom_range(0, 255));
      end
      i_key_wr     = ($urandom_range(0, 15) == 0);
      i_key_idx    = 4'($urandom_range(0, 15));
      i_key_char   = 8'(SQ[$urandom_range(0, 24)]);
      i_key_len_wr = (!i_in_valid || i_in_sop) && ($urandom_range(0, 19) == 0);
      i_key_len    = 5'($urandom_range(0, 31));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; i_in_valid = 1'b0; i_key_wr = 1'b0; i_key_len_wr = 1'b0; i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
